// File: rtl/maxpool_stream.sv
// Streaming max-pool: per-beat lane comparator tree feeding a window accumulator.
// Define MAXPOOL_ARGMAX_EN to build {beat, lane} index tracking; otherwise RESULT_IDX is 0.
module maxpool_stream #(
  parameter int DW     = 16,
  parameter int N      = 4,
  parameter int BEATW  = 4,
  parameter int SIGNED = 0
) (
  input  logic                            CLK,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [DW*N-1:0]                 PATCH,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   RESULT,
  output logic [BEATW+$clog2(N)-1:0]      RESULT_IDX
);

  localparam int L  = $clog2(N);
  localparam int IW = BEATW + L;

  logic en;

  // Tree stage inputs: index 0 is the incoming beat, index s is register stage s.
  logic [DW-1:0] src_val  [0:L-1][0:N-1];
  logic          src_last [0:L-1];
  logic          src_vld  [0:L-1];

  logic [DW-1:0] val_d  [1:L][0:N-1];
  logic [DW-1:0] val_q  [1:L][0:N-1];
  logic          last_d [1:L];
  logic          last_q [1:L];
  logic          vld_d  [1:L];
  logic          vld_q  [1:L];

  logic [DW-1:0] acc_val_d, acc_val_q;
  logic          acc_full_d, acc_full_q;
  logic [DW-1:0] res_val_d, res_val_q;
  logic          out_valid_d, out_valid_q;
  logic          take;
  logic [DW-1:0] merged_val;

`ifdef MAXPOOL_ARGMAX_EN
  logic [L-1:0]     src_lane [0:L-1][0:N-1];
  logic [BEATW-1:0] src_beat [0:L-1];
  logic [L-1:0]     lane_d   [1:L][0:N-1];
  logic [L-1:0]     lane_q   [1:L][0:N-1];
  logic [BEATW-1:0] beat_d   [1:L];
  logic [BEATW-1:0] beat_q   [1:L];
  logic [BEATW-1:0] beat_cnt_d, beat_cnt_q;
  logic [IW-1:0]    acc_idx_d, acc_idx_q;
  logic [IW-1:0]    res_idx_d, res_idx_q;
  logic [IW-1:0]    merged_idx;
`endif

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign RESULT    = res_val_q;
`ifdef MAXPOOL_ARGMAX_EN
  assign RESULT_IDX = res_idx_q;
`else
  assign RESULT_IDX = '0;
`endif

  always_comb begin
    for (int k = 0; k < N; k++) begin
      src_val[0][k] = PATCH[DW*k +: DW];
`ifdef MAXPOOL_ARGMAX_EN
      src_lane[0][k] = L'(k);
`endif
    end
    src_last[0] = in_last;
    src_vld[0]  = in_valid;
`ifdef MAXPOOL_ARGMAX_EN
    src_beat[0] = beat_cnt_q;
`endif
    for (int s = 1; s < L; s++) begin
      for (int k = 0; k < N; k++) begin
        src_val[s][k] = val_q[s][k];
`ifdef MAXPOOL_ARGMAX_EN
        src_lane[s][k] = lane_q[s][k];
`endif
      end
      src_last[s] = last_q[s];
      src_vld[s]  = vld_q[s];
`ifdef MAXPOOL_ARGMAX_EN
      src_beat[s] = beat_q[s];
`endif
    end
  end

  // Right operand wins only when strictly greater, so ties keep the lower lane.
  always_comb begin
    for (int s = 1; s <= L; s++) begin
      for (int j = 0; j < N; j++) begin
        val_d[s][j] = '0;
`ifdef MAXPOOL_ARGMAX_EN
        lane_d[s][j] = '0;
`endif
      end
      for (int j = 0; j < (N >> s); j++) begin
        if (gt(src_val[s-1][2*j+1], src_val[s-1][2*j])) begin
          val_d[s][j] = src_val[s-1][2*j+1];
`ifdef MAXPOOL_ARGMAX_EN
          lane_d[s][j] = src_lane[s-1][2*j+1];
`endif
        end else begin
          val_d[s][j] = src_val[s-1][2*j];
`ifdef MAXPOOL_ARGMAX_EN
          lane_d[s][j] = src_lane[s-1][2*j];
`endif
        end
      end
      last_d[s] = src_last[s-1];
      vld_d[s]  = src_vld[s-1];
`ifdef MAXPOOL_ARGMAX_EN
      beat_d[s] = src_beat[s-1];
`endif
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (in_valid && en) begin
      if (in_last)
        beat_cnt_d = '0;
      else if (beat_cnt_q != {BEATW{1'b1}})
        beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    take        = !acc_full_q || gt(val_q[L][0], acc_val_q);
    merged_val  = take ? val_q[L][0] : acc_val_q;
    acc_val_d   = acc_val_q;
    acc_full_d  = acc_full_q;
    res_val_d   = res_val_q;
    out_valid_d = out_valid_q;
`ifdef MAXPOOL_ARGMAX_EN
    merged_idx  = take ? {beat_q[L], lane_q[L][0]} : acc_idx_q;
    acc_idx_d   = acc_idx_q;
    res_idx_d   = res_idx_q;
`endif
    if (en) begin
      out_valid_d = 1'b0;
      if (vld_q[L]) begin
        if (last_q[L]) begin
          res_val_d   = merged_val;
          out_valid_d = 1'b1;
          acc_full_d  = 1'b0;
          acc_val_d   = '0;
`ifdef MAXPOOL_ARGMAX_EN
          res_idx_d   = merged_idx;
          acc_idx_d   = '0;
`endif
        end else begin
          acc_val_d  = merged_val;
          acc_full_d = 1'b1;
`ifdef MAXPOOL_ARGMAX_EN
          acc_idx_d  = merged_idx;
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      val_q       <= '{default: '0};
      last_q      <= '{default: '0};
      vld_q       <= '{default: '0};
      acc_val_q   <= '0;
      acc_full_q  <= 1'b0;
      res_val_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      lane_q      <= '{default: '0};
      beat_q      <= '{default: '0};
      beat_cnt_q  <= '0;
      acc_idx_q   <= '0;
      res_idx_q   <= '0;
`endif
    end else begin
      if (en) begin
        val_q  <= val_d;
        last_q <= last_d;
        vld_q  <= vld_d;
`ifdef MAXPOOL_ARGMAX_EN
        lane_q <= lane_d;
        beat_q <= beat_d;
`endif
      end
      acc_val_q   <= acc_val_d;
      acc_full_q  <= acc_full_d;
      res_val_q   <= res_val_d;
      out_valid_q <= out_valid_d;
`ifdef MAXPOOL_ARGMAX_EN
      beat_cnt_q  <= beat_cnt_d;
      acc_idx_q   <= acc_idx_d;
      res_idx_q   <= res_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench: unsigned and signed instances share stimulus; a window-level
// reference model predicts each result and negedge monitors pop and compare.
module tb_maxpool_stream;
  localparam int DW = 16, N = 4, BEATW = 4, L = 2, IW = 6;

  typedef struct {
    logic [15:0] val;
    logic [5:0]  idx;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [63:0] patch;
  logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [15:0] result_u, result_s;
  logic [5:0]  idx_u, idx_s;

  exp_t        exp_u[$], exp_s[$];
  logic [63:0] win[$];
  int          n_checks = 0, n_fail = 0;
  int          got_u = 0, got_s = 0;
  logic [15:0] last_val_u, last_val_s;
  logic [5:0]  last_idx_u, last_idx_s;

  maxpool_stream #(.DW(DW), .N(N), .BEATW(BEATW), .SIGNED(0)) u_dut_u (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_last(in_last),
    .PATCH(patch), .out_valid(out_valid_u), .out_ready(out_ready), .RESULT(result_u), .RESULT_IDX(idx_u));

  maxpool_stream #(.DW(DW), .N(N), .BEATW(BEATW), .SIGNED(1)) u_dut_s (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .PATCH(patch), .out_valid(out_valid_s), .out_ready(out_ready), .RESULT(result_s), .RESULT_IDX(idx_s));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] xi(input logic [5:0] i);
`ifdef MAXPOOL_ARGMAX_EN
    return i;
`else
    return 6'd0;
`endif
  endfunction

  // Reference: scan beats then lanes in order; only a strictly larger element displaces the best.
  function automatic exp_t model(input bit sgn);
    exp_t        e;
    logic [15:0] bv, v;
    logic [63:0] p;
    int          bb, bl;
    bit          have, gtr;
    have = 0; bv = '0; bb = 0; bl = 0;
    foreach (win[b]) begin
      p = win[b];
      for (int k = 0; k < 4; k++) begin
        v   = p[16*k +: 16];
        gtr = sgn ? ($signed(v) > $signed(bv)) : (v > bv);
        if (!have || gtr) begin
          have = 1; bv = v; bb = (b > 15) ? 15 : b; bl = k;
        end
      end
    end
    e.val = bv;
    e.idx = xi({bb[3:0], bl[1:0]});
    return e;
  endfunction

  always @(negedge CLK) begin
    if (rst_n && in_valid && in_ready_u) begin
      win.push_back(patch);
      if (in_last) begin
        exp_u.push_back(model(1'b0));
        exp_s.push_back(model(1'b1));
        win.delete();
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (rst_n && out_valid_u && out_ready) begin
      if (exp_u.size() == 0) check("unexpected_result_u", 32'(result_u), 32'hDEAD_BEEF);
      else begin
        e = exp_u.pop_front();
        $display("result_u val=%0h idx=%0h exp_val=%0h exp_idx=%0h", result_u, idx_u, e.val, e.idx);
        check("result_u", 32'(result_u), 32'(e.val));
        check("idx_u", 32'(idx_u), 32'(e.idx));
      end
      last_val_u = result_u; last_idx_u = idx_u; got_u++;
    end
    if (rst_n && out_valid_s && out_ready) begin
      if (exp_s.size() == 0) check("unexpected_result_s", 32'(result_s), 32'hDEAD_BEEF);
      else begin
        e = exp_s.pop_front();
        $display("result_s val=%0h idx=%0h exp_val=%0h exp_idx=%0h", result_s, idx_s, e.val, e.idx);
        check("result_s", 32'(result_s), 32'(e.val));
        check("idx_s", 32'(idx_s), 32'(e.idx));
      end
      last_val_s = result_s; last_idx_s = idx_s; got_s++;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [63:0] p, input bit last);
    bit acc;
    acc = 0;
    in_valid = 1'b1; patch = p; in_last = last;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge CLK);
      acc = in_ready_u;
      @(posedge CLK); #1;
    end
    if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_got(input int target_u, input int target_s);
    for (int t = 0; t < 200 && (got_u < target_u || got_s < target_s); t++) @(negedge CLK);
    if (got_u < target_u || got_s < target_s) check("result_timeout", 32'(got_u), 32'(target_u));
    @(posedge CLK); #1;
  endtask

  function automatic logic [63:0] rand_patch();
    logic [63:0] p;
    int          mode;
    logic [15:0] edges [4];
    edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFF; edges[3] = 16'h0000;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 4; k++) begin
      case (mode)
        0:       p[16*k +: 16] = 16'($urandom);
        1:       p[16*k +: 16] = 16'($urandom_range(0, 3));
        default: p[16*k +: 16] = edges[$urandom_range(0, 3)];
      endcase
    end
    return p;
  endfunction

  initial begin
    int  lat, bu, bs;
    time t0;
    bit  done;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; patch = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid_u), 32'd0);
    check("rst_in_ready", 32'(in_ready_u), 32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Single beat: value and latency.
    bu = got_u; bs = got_s;
    send_beat(64'h0003_0002_0001_0000, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge CLK);
      if (out_valid_u) lat = k;
    end
    @(posedge CLK); #1;
    check("latency", 32'(lat), 32'd3);
    wait_got(bu + 1, bs + 1);
    check("single_val", 32'(last_val_u), 32'd3);
    check("single_idx", 32'(last_idx_u), 32'(xi(6'd3)));

    // Three-beat window.
    bu = got_u; bs = got_s;
    send_beat(64'h0003_0002_0001_0000, 1'b0);
    send_beat(64'h000D_000C_000B_000A, 1'b0);
    send_beat(64'h0017_0016_0015_0014, 1'b1);
    wait_got(bu + 1, bs + 1);
    check("three_val", 32'(last_val_u), 32'd23);
    check("three_idx", 32'(last_idx_u), 32'(xi({4'd2, 2'd3})));

    // Ties everywhere resolve to beat 0, lane 0.
    bu = got_u; bs = got_s;
    send_beat(64'h0007_0007_0007_0007, 1'b0);
    send_beat(64'h0007_0007_0007_0007, 1'b1);
    wait_got(bu + 1, bs + 1);
    check("tie_val", 32'(last_val_u), 32'd7);
    check("tie_idx", 32'(last_idx_u), 32'(xi(6'd0)));

    // Signed versus unsigned compare.
    bu = got_u; bs = got_s;
    send_beat(64'hFFFF_0001_8000_FFFE, 1'b1);
    wait_got(bu + 1, bs + 1);
    check("uns_val", 32'(last_val_u), 32'hFFFF);
    check("uns_idx", 32'(last_idx_u), 32'(xi(6'd3)));
    check("sgn_val", 32'(last_val_s), 32'h0001);
    check("sgn_idx", 32'(last_idx_s), 32'(xi(6'd2)));

    // Back-to-back single-beat windows at one beat per cycle.
    t0 = $time;
    for (int i = 0; i < 8; i++) send_beat(rand_patch(), 1'b1);
    check("burst_cycles", 32'(($time - t0) / 10), 32'd8);
    idle(6);

    // Backpressure: result held, input stalled, next window follows on release.
    bu = got_u; bs = got_s;
    out_ready = 1'b0;
    send_beat(64'h0000_0040_0000_0000, 1'b1);
    send_beat(64'h0000_0000_0000_0050, 1'b1);
    for (int t = 0; t < 20 && !out_valid_u; t++) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready_u), 32'd0);
      check("bp_valid", 32'(out_valid_u), 32'd1);
      check("bp_hold_val", 32'(result_u), 32'h40);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    wait_got(bu + 2, bs + 2);
    check("bp_next_val", 32'(last_val_u), 32'h50);

    // Reset mid-stream with a pending result and a partial window.
    out_ready = 1'b0;
    send_beat(64'h0001_0001_0001_0001, 1'b1);
    send_beat(64'h0009_0009_0009_0009, 1'b0);
    send_beat(64'h0009_0009_0009_0009, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_u", 32'(out_valid_u), 32'd0);
    check("mid_rst_result_u", 32'(result_u), 32'd0);
    check("mid_rst_idx_u", 32'(idx_u), 32'd0);
    check("mid_rst_in_ready_u", 32'(in_ready_u), 32'd1);
    check("mid_rst_valid_s", 32'(out_valid_s), 32'd0);
    check("mid_rst_result_s", 32'(result_s), 32'd0);
    win.delete(); exp_u.delete(); exp_s.delete();
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bu = got_u; bs = got_s;
    send_beat(64'h0005_0009_0001_0002, 1'b1);
    wait_got(bu + 1, bs + 1);
    check("post_rst_val", 32'(last_val_u), 32'd9);
    check("post_rst_idx", 32'(last_idx_u), 32'(xi(6'd2)));

    // Random windows under random backpressure, including one longer than 2^BEATW beats.
    done = 0;
    fork
      begin
        for (int w = 0; w < 30; w++) begin
          int len;
          len = (w == 10) ? 20 : $urandom_range(1, 4);
          for (int b = 0; b < len; b++) send_beat(rand_patch(), b == len - 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge CLK); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 500 && (exp_u.size() != 0 || exp_s.size() != 0); t++) @(negedge CLK);
    check("drain_u", 32'(exp_u.size()), 32'd0);
    check("drain_s", 32'(exp_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
